ahb_lite_mem_subordinate: RTL and testbench



---
 rtl/ahb_lite_mem_subordinate_if.sv | 25 ++
 rtl/ahb_lite_mem_subordinate.sv | 85 ++++++++
 tb/tb_ahb_lite_mem_subordinate.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_mem_subordinate_if.sv
// ahb_lite_mem_subordinate_if: AHB-Lite bus bundle between manager/interconnect and subordinate
interface ahb_lite_mem_subordinate_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;
  logic                  HREADYOUT;
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HRESP, HREADYOUT
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_lite_mem_subordinate.sv
// ahb_lite_mem_subordinate: AHB-Lite memory subordinate with wait states, byte lanes and a read-only region
module ahb_lite_mem_subordinate #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_mem_subordinate_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic act, wr, accept, err, done, unused;
  logic [IDX_W-1:0] idx;
  logic [LANE_W-1:0] off;
  logic [2:0] size;
  logic [IDX_W:0] a_idx;
  logic [BYTES-1:0] be;
  // one extra index bit so addresses just past the array decode as out of range
  assign a_idx = bus.HADDR[LANE_W+IDX_W:LANE_W];
  assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && bus.HREADYOUT;
  assign err = bus.HSIZE > 3'(LANE_W)
            || |(bus.HADDR[LANE_W-1:0] & ~({LANE_W{1'b1}} << bus.HSIZE))
            || a_idx >= DEPTH
            || (bus.HWRITE && int'({1'b0, a_idx}) < RO_WORDS);
  assign done = state == IDLE && act;
  assign bus.HREADYOUT = state == IDLE || state == ERR2;
  assign bus.HRESP = state == ERR1 || state == ERR2;
  assign bus.HRDATA = act && !wr && (state == IDLE || state == WAIT) ? mem[idx] : '0;
  assign unused = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR[ADDR_WIDTH-1:LANE_W+IDX_W+1]};
  always_comb begin
    state_n = IDLE;
    cnt_n = cnt;
    if (state == WAIT) begin
      cnt_n = cnt - 1'b1;
      state_n = cnt == 4'd1 ? IDLE : WAIT;
    end else if (state == ERR1) begin
      state_n = ERR2;
    end else if (accept) begin
      state_n = err ? ERR1 : WS != 4'd0 ? WAIT : IDLE;
      cnt_n = WS;
    end
  end
  // aligned transfers: a lane belongs to the beat when it shares the size-aligned group of the offset
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) be[b] = (LANE_W'(b) >> size) == (off >> size);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      cnt <= '0;
      act <= 1'b0;
      wr <= 1'b0;
      idx <= '0;
      off <= '0;
      size <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        act <= 1'b1;
        wr <= bus.HWRITE;
        idx <= a_idx[IDX_W-1:0];
        off <= bus.HADDR[LANE_W-1:0];
        size <= bus.HSIZE;
      end else if (done || state == ERR2) begin
        act <= 1'b0;
      end
    end
  end
  always_ff @(posedge HCLK)
    if (!HRESET && done && wr)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
endmodule

// File: tb/tb_ahb_lite_mem_subordinate.sv
// tb_ahb_lite_mem_subordinate: directed AHB-Lite traffic on a zero-wait and a two-wait instance against a transaction model
module tb_ahb_lite_mem_subordinate;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic [1:0] sel = 2'b00;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [1:0] s_trans = 2'b00;
  logic s_write = 1'b0;
  logic [2:0] s_size = 3'd0, s_burst = 3'd0;

  ahb_lite_mem_subordinate_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  ahb_lite_mem_subordinate_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  assign bus0.HSEL = sel[0];
  assign bus0.HADDR = s_addr;
  assign bus0.HTRANS = s_trans;
  assign bus0.HWRITE = s_write;
  assign bus0.HSIZE = s_size;
  assign bus0.HBURST = s_burst;
  assign bus0.HWDATA = s_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HSEL = sel[1];
  assign bus2.HADDR = s_addr;
  assign bus2.HTRANS = s_trans;
  assign bus2.HWRITE = s_write;
  assign bus2.HSIZE = s_size;
  assign bus2.HBURST = s_burst;
  assign bus2.HWDATA = s_wdata;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_lite_mem_subordinate #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(0), .RO_WORDS(1))
    u0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0));
  ahb_lite_mem_subordinate #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(2), .RO_WORDS(0))
    u2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2));

  logic [1:0] rdy, resp;
  logic [31:0] rd [2];
  assign rdy = {bus2.HREADYOUT, bus0.HREADYOUT};
  assign resp = {bus2.HRESP, bus0.HRESP};
  assign rd[0] = bus0.HRDATA;
  assign rd[1] = bus2.HRDATA;

  int n_cmp = 0, n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // model: every accepted transfer expands into its list of expected data-phase cycles
  typedef struct {
    logic rdy;
    logic resp;
    logic rd;
    logic wr;
    logic last;
    int idx;
    int off;
    int size;
  } ent_t;
  ent_t q [2][$];
  ent_t idle;
  int ws [2] = '{0, 2};
  int ro [2] = '{1, 0};
  logic [31:0] mm [2][16];
  logic [3:0] mv [2][16];

  task automatic model_accept(input int d);
    ent_t e;
    int idx;
    bit err;
    idx = int'((s_addr >> 2) & 32'd31);
    err = s_size > 3'd2 || (s_addr % (32'd1 << s_size)) != 0 || idx >= 16 || (s_write && idx < ro[d]);
    e.idx = idx;
    e.off = int'(s_addr & 32'd3);
    e.size = int'(s_size);
    e.wr = s_write && !err;
    e.rd = !s_write && !err;
    e.resp = err;
    e.rdy = 1'b0;
    e.last = 1'b0;
    if (err) q[d].push_back(e);
    else repeat (ws[d]) q[d].push_back(e);
    e.rdy = 1'b1;
    e.last = 1'b1;
    q[d].push_back(e);
  endtask

  initial begin
    idle.rdy = 1'b1;
    idle.resp = 1'b0;
    idle.rd = 1'b0;
    idle.wr = 1'b0;
    idle.last = 1'b0;
    idle.idx = 0;
    idle.off = 0;
    idle.size = 0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) mv[d][w] = 4'h0;
    forever begin
      @(posedge HCLK);
      for (int d = 0; d < 2; d++) begin
        if (HRESET) begin
          q[d].delete();
        end else begin
          if (q[d].size() > 0) begin
            ent_t e;
            e = q[d].pop_front();
            if (e.last && e.wr)
              for (int b = 0; b < 4; b++)
                if (b >= e.off && b < e.off + (1 << e.size)) begin
                  mm[d][e.idx][8*b +: 8] = s_wdata[8*b +: 8];
                  mv[d][e.idx][b] = 1'b1;
                end
          end
          if (q[d].size() == 0 && sel[d] && s_trans[1]) model_accept(d);
        end
      end
    end
  end

  initial forever begin
    @(negedge HCLK);
    if (armed)
      for (int d = 0; d < 2; d++) begin
        ent_t e;
        logic [31:0] x;
        e = q[d].size() > 0 ? q[d][0] : idle;
        x = e.rd ? mm[d][e.idx] : 32'h0;
        chk($sformatf("dut%0d_hreadyout", d), 32'(rdy[d]), 32'(e.rdy));
        chk($sformatf("dut%0d_hresp", d), 32'(resp[d]), 32'(e.resp));
        if (!e.rd || mv[d][e.idx] == 4'hF) chk($sformatf("dut%0d_hrdata", d), rd[d], x);
      end
  end

  // beat list for the pipelined driver
  logic [31:0] b_addr [16], b_data [16];
  logic [1:0] b_trans [16];
  logic b_write [16];
  logic [2:0] b_size [16];
  int nb = 0;
  logic [31:0] obs_rd [16];
  logic obs_resp [16];
  int obs_cycles, obs_zero;

  task automatic add(input logic [1:0] t, input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] v);
    b_trans[nb] = t;
    b_write[nb] = w;
    b_size[nb] = sz;
    b_addr[nb] = a;
    b_data[nb] = v;
    nb++;
  endtask

  task automatic drive(input int d, input int ai, input int di);
    sel = 2'b00;
    if (ai < nb) begin
      sel[d] = 1'b1;
      s_trans = b_trans[ai];
      s_write = b_write[ai];
      s_size = b_size[ai];
      s_addr = b_addr[ai];
    end else begin
      s_trans = 2'b00;
      s_write = 1'b0;
      s_size = 3'd0;
      s_addr = '0;
    end
    s_wdata = di >= 0 ? b_data[di] : '0;
  endtask

  task automatic run(input int d);
    int ai, di, cyc;
    logic r;
    ai = 0;
    di = -1;
    cyc = 0;
    obs_cycles = 0;
    obs_zero = 0;
    drive(d, ai, di);
    while (ai < nb || di >= 0) begin
      @(negedge HCLK);
      r = rdy[d];
      if (di >= 0) begin
        obs_cycles++;
        if (!r) obs_zero++;
        else begin
          obs_rd[di] = rd[d];
          obs_resp[di] = resp[d];
        end
      end
      @(posedge HCLK);
      #1;
      if (r) begin
        di = (ai < nb && b_trans[ai][1]) ? ai : -1;
        ai++;
        drive(d, ai, di);
      end
      cyc++;
      if (cyc > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_dut%0d: got %0d cycles required at most 200", d, cyc);
        break;
      end
    end
    nb = 0;
    drive(d, 0, -1);
    sel = 2'b00;
    s_trans = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before 2 ms");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    armed = 1'b1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset_hreadyout", 32'(rdy), 32'h3);
    chk("reset_hresp", 32'(resp), 32'h0);
    chk("reset_hrdata0", rd[0], 32'h0);
    chk("reset_hrdata2", rd[1], 32'h0);
    @(posedge HCLK);
    #1;

    add(2'b10, 1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    add(2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    run(0);
    chk("write_then_read", obs_rd[1], 32'hDEADBEEF);
    chk("zero_wait_cycles", 32'(obs_cycles), 32'd2);

    add(2'b10, 1'b1, 3'd2, 32'h0C, 32'h11223344);
    add(2'b10, 1'b1, 3'd0, 32'h0D, 32'h0000AA00);
    add(2'b10, 1'b0, 3'd2, 32'h0C, 32'h0);
    add(2'b01, 1'b0, 3'd2, 32'h10, 32'h0);
    add(2'b10, 1'b1, 3'd1, 32'h0E, 32'h55660000);
    add(2'b10, 1'b0, 3'd2, 32'h0C, 32'h0);
    add(2'b10, 1'b1, 3'd2, 32'h04, 32'hCAFEF00D);
    run(0);
    chk("byte_write", obs_rd[2], 32'h1122AA44);
    chk("halfword_write", obs_rd[5], 32'h5566AA44);

    add(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    add(2'b10, 1'b0, 3'd3, 32'h00, 32'h0);
    add(2'b10, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 3'd2, 32'h00, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 3'd1, 32'h09, 32'hFFFFFFFF);
    add(2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
    add(2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    run(0);
    chk("err_range_resp", 32'(obs_resp[0]), 32'h1);
    chk("err_ro_resp", 32'(obs_resp[3]), 32'h1);
    chk("err2_accept_data", obs_rd[5], 32'hCAFEF00D);
    chk("err2_accept_resp", 32'(obs_resp[5]), 32'h0);
    chk("err_mem_unchanged", obs_rd[6], 32'hDEADBEEF);
    chk("err_seq_cycles", 32'(obs_cycles), 32'd12);

    add(2'b10, 1'b1, 3'd2, 32'h10, 32'hA5A5A5A5);
    run(1);
    add(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run(1);
    chk("ws2_read_cycles", 32'(obs_cycles), 32'd3);
    chk("ws2_read_waits", 32'(obs_zero), 32'd2);
    chk("ws2_read_data", obs_rd[0], 32'hA5A5A5A5);

    s_burst = 3'b011;
    add(2'b10, 1'b1, 3'd2, 32'h00, 32'h10000000);
    add(2'b11, 1'b1, 3'd2, 32'h04, 32'h10000001);
    add(2'b11, 1'b1, 3'd2, 32'h08, 32'h10000002);
    add(2'b11, 1'b1, 3'd2, 32'h0C, 32'h10000003);
    run(1);
    chk("incr4_write_cycles", 32'(obs_cycles), 32'd12);
    add(2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
    add(2'b11, 1'b0, 3'd2, 32'h04, 32'h0);
    add(2'b11, 1'b0, 3'd2, 32'h08, 32'h0);
    add(2'b11, 1'b0, 3'd2, 32'h0C, 32'h0);
    run(1);
    s_burst = 3'b000;
    chk("incr4_read_last", obs_rd[3], 32'h10000003);

    add(2'b10, 1'b1, 3'd2, 32'h14, 32'h12345678);
    run(1);
    sel = 2'b10;
    s_addr = 32'h14;
    s_trans = 2'b10;
    s_write = 1'b1;
    s_size = 3'd2;
    @(posedge HCLK);
    #1;
    sel = 2'b00;
    s_trans = 2'b00;
    s_write = 1'b0;
    s_wdata = 32'h0BAD0BAD;
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("mid_reset_waiting", 32'(rdy[1]), 32'h0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    s_wdata = '0;
    @(negedge HCLK);
    chk("after_reset_hreadyout", 32'(rdy[1]), 32'h1);
    chk("after_reset_hrdata", rd[1], 32'h0);
    @(posedge HCLK);
    #1;
    add(2'b10, 1'b0, 3'd2, 32'h14, 32'h0);
    run(1);
    chk("mem_kept_over_reset", obs_rd[0], 32'h12345678);

    add(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    run(1);
    chk("ws2_err_cycles", 32'(obs_cycles), 32'd2);
    chk("ws2_err_resp", 32'(obs_resp[0]), 32'h1);

    repeat (3) @(posedge HCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
